// File: rtl/fetch_bus_responder.sv
// fetch_bus_responder
//   Serves the fetch stage's block-read protocol from a narrow instruction
//   memory port. A block of FETCH_WIDTH instructions starting at the
//   requested pc is assembled from FETCH_WIDTH sequential word reads, then
//   returned with a one-cycle ack. A change of the requested address during
//   a fill aborts it; an unacknowledged memory beat is drained first so that
//   the memory port never sees a dropped request.
//
//   Optional feature: define FETCH_BUS_LINE_BUFFER_EN to keep a one-entry
//   buffer of the last completed block, answered without memory traffic and
//   cleared by fetch_bus_invalidate.
//
// Ports
//   clk                   clock
//   rst                   synchronous active-high reset
//   fetch_bus_addr        requested block start address (4-byte aligned pc)
//   fetch_bus_read_req    block read request
//   fetch_bus_invalidate  fence.i pulse (line buffer only)
//   bus_fetch_data        block data, slot i = word at addr+4*i
//   bus_fetch_read_ack    one-cycle block-valid pulse
//   ibus_addr             memory word address
//   ibus_read_req         memory read request
//   ibus_data             memory read data, valid with ibus_read_ack
//   ibus_read_ack         memory ack (may coincide with ibus_read_req)
module fetch_bus_responder #(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned FETCH_WIDTH       = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ADDR_WIDTH-1:0]                      fetch_bus_addr,
    input  logic                                       fetch_bus_read_req,
    input  logic                                       fetch_bus_invalidate,
    output logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0]   bus_fetch_data,
    output logic                                       bus_fetch_read_ack,
    output logic [ADDR_WIDTH-1:0]                      ibus_addr,
    output logic                                       ibus_read_req,
    input  logic [INSTRUCTION_WIDTH-1:0]               ibus_data,
    input  logic                                       ibus_read_ack
);

    localparam int unsigned BEAT_W = $clog2(FETCH_WIDTH);
    localparam int unsigned DATA_W = INSTRUCTION_WIDTH * FETCH_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_e;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   ibus_addr_q, ibus_addr_d;
    logic                    ibus_req_q, ibus_req_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]       data_q, data_d;

    logic                    abort;
    logic                    last_beat;
    logic                    do_capture;
    logic                    cap_valid;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    fill_done;

    logic                    lb_valid;
    logic [ADDR_WIDTH-1:0]   lb_tag;
    logic [DATA_W-1:0]       lb_rdata;

`ifdef FETCH_BUS_LINE_BUFFER_EN
    logic                    lb_valid_q;
    logic [ADDR_WIDTH-1:0]   lb_tag_q;
    logic [DATA_W-1:0]       lb_data_q;

    // Invalidate is applied after the fill update so it wins a same-cycle tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
        end else begin
            if (fill_done) begin
                lb_valid_q <= 1'b1;
                lb_tag_q   <= addr_q;
                lb_data_q  <= data_d;
            end
            if (fetch_bus_invalidate) begin
                lb_valid_q <= 1'b0;
            end
        end
    end

    assign lb_valid = lb_valid_q;
    assign lb_tag   = lb_tag_q;
    assign lb_rdata = lb_data_q;
`else
    assign lb_valid = 1'b0;
    assign lb_tag   = '0;
    assign lb_rdata = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            addr_q       <= '0;
            ibus_addr_q  <= '0;
            ibus_req_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            ibus_addr_q  <= ibus_addr_d;
            ibus_req_q   <= ibus_req_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        ibus_addr_d  = ibus_addr_q;
        ibus_req_d   = ibus_req_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        data_d       = data_q;
        fill_done    = 1'b0;
        do_capture   = 1'b0;
        cap_valid    = fetch_bus_read_req;
        cap_addr     = fetch_bus_addr;
        abort        = !fetch_bus_read_req || (fetch_bus_addr != addr_q);
        last_beat    = (beat_q == BEAT_W'(FETCH_WIDTH - 1));

        case (state_q)
            IDLE, RESP: begin
                do_capture = 1'b1;
            end
            READ: begin
                if (abort) begin
                    // An acked beat frees the port at once; otherwise the
                    // outstanding beat must be drained before redirecting.
                    if (ibus_read_ack) begin
                        do_capture = 1'b1;
                    end else begin
                        state_d      = DRAIN;
                        pend_valid_d = fetch_bus_read_req;
                        pend_addr_d  = fetch_bus_addr;
                    end
                end else if (ibus_read_ack) begin
                    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                        if (beat_q == BEAT_W'(i)) begin
                            data_d[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = ibus_data;
                        end
                    end
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d    = RESP;
                        ibus_req_d = 1'b0;
                        fill_done  = 1'b1;
                    end else begin
                        ibus_addr_d = addr_q + ADDR_WIDTH'({beat_d, 2'b00});
                    end
                end
            end
            DRAIN: begin
                if (fetch_bus_read_req) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = fetch_bus_addr;
                end
                if (ibus_read_ack) begin
                    do_capture   = 1'b1;
                    cap_valid    = pend_valid_d;
                    cap_addr     = pend_addr_d;
                    pend_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_capture) begin
            ibus_req_d = 1'b0;
            if (cap_valid) begin
                addr_d = cap_addr;
                beat_d = '0;
                if (cap_addr[1:0] != 2'b00) begin
                    state_d = RESP;
                    data_d  = '0;
                end else if (lb_valid && !fetch_bus_invalidate && (cap_addr == lb_tag)) begin
                    state_d = RESP;
                    data_d  = lb_rdata;
                end else begin
                    state_d     = READ;
                    ibus_req_d  = 1'b1;
                    ibus_addr_d = cap_addr;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign bus_fetch_read_ack = (state_q == RESP);
    assign bus_fetch_data     = data_q;
    assign ibus_addr          = ibus_addr_q;
    assign ibus_read_req      = ibus_req_q;

endmodule

// File: tb/tb_fetch_bus_responder.sv
// tb_fetch_bus_responder
//   Directed scenarios for fill, misaligned, redirect/drain, back-to-back,
//   reset and (when enabled) line-buffer behaviour, followed by randomized
//   requests against a zero/short-wait memory model. Block contents are
//   predicted from a static memory function.
module tb_fetch_bus_responder;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int FW = 4;
    localparam int DW = IW * FW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] fetch_bus_addr = '0;
    logic          fetch_bus_read_req = 1'b0;
    logic          fetch_bus_invalidate = 1'b0;
    logic [DW-1:0] bus_fetch_data;
    logic          bus_fetch_read_ack;
    logic [AW-1:0] ibus_addr;
    logic          ibus_read_req;
    logic [IW-1:0] ibus_data = '0;
    logic          ibus_read_ack = 1'b0;

    fetch_bus_responder #(
        .ADDR_WIDTH        (AW),
        .INSTRUCTION_WIDTH (IW),
        .FETCH_WIDTH       (FW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_bus_addr       (fetch_bus_addr),
        .fetch_bus_read_req   (fetch_bus_read_req),
        .fetch_bus_invalidate (fetch_bus_invalidate),
        .bus_fetch_data       (bus_fetch_data),
        .bus_fetch_read_ack   (bus_fetch_read_ack),
        .ibus_addr            (ibus_addr),
        .ibus_read_req        (ibus_read_req),
        .ibus_data            (ibus_data),
        .ibus_read_ack        (ibus_read_ack)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            passed = 0;
    int            ibus_cnt = 0;
    int            mem_wait = 0;
    int            wait_left = 0;
    logic          mem_busy = 1'b0;
    logic [AW-1:0] last_ibus_addr = '0;

    // Memory contents: a known pattern for the first block at 0x80000000,
    // a scrambled function of the address elsewhere.
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        if (a[31:4] == 28'h8000000)
            return IW'((int'(a[3:2]) + 1) * 17);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [DW-1:0] exp_block(input logic [AW-1:0] a);
        logic [DW-1:0] b;
        b = '0;
        if (a[1:0] == 2'b00)
            for (int i = 0; i < FW; i++)
                b[i*IW +: IW] = mem_word(a + AW'(4 * i));
        return b;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] a;
        case ($urandom_range(0, 5))
            0:       a = 32'hFFFF_FFF8;
            1, 2:    a = 32'h8000_0000 + AW'(4 * $urandom_range(0, 7));
            default: a = 32'($urandom) & 32'hFFFF_FFFC;
        endcase
        if ($urandom_range(0, 7) == 0)
            a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the middle of the next cycle, then play the memory side for
    // that cycle and check the hold-until-ack rule on the ibus request.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (mem_busy)
            check("ibus_hold", {ibus_read_req, ibus_addr}, {1'b1, last_ibus_addr});
        if (ibus_read_req) begin
            ibus_cnt++;
            if (!mem_busy) begin
                wait_left      = mem_wait;
                mem_busy       = 1'b1;
                last_ibus_addr = ibus_addr;
            end
            if (wait_left == 0) begin
                ibus_read_ack = 1'b1;
                ibus_data     = mem_word(ibus_addr);
                mem_busy      = 1'b0;
            end else begin
                wait_left--;
                ibus_read_ack = 1'b0;
                ibus_data     = $urandom;
            end
        end else begin
            mem_busy      = 1'b0;
            ibus_read_ack = 1'b0;
            ibus_data     = $urandom;
        end
    endtask

    task automatic invalidate_cycle();
        fetch_bus_invalidate = 1'b1;
        cyc();
        fetch_bus_invalidate = 1'b0;
    endtask

    initial begin
        int stall;
        int acks;
        logic [AW-1:0] redir_exp [10];

        // Reset state
        cyc();
        cyc();
        check("rst_ack", bus_fetch_read_ack, 1'b0);
        check("rst_data", bus_fetch_data, '0);
        check("rst_ibus_req", ibus_read_req, 1'b0);
        check("rst_ibus_addr", ibus_addr, '0);
        rst = 1'b0;
        cyc();

        // Aligned block, zero-wait memory
        invalidate_cycle();
        fetch_bus_read_req = 1'b1;
        fetch_bus_addr     = 32'h8000_0000;
        for (int i = 0; i < FW; i++) begin
            cyc();
            check("fill_ibus_req", ibus_read_req, 1'b1);
            check("fill_ibus_addr", ibus_addr, 32'h8000_0000 + AW'(4 * i));
            check("fill_no_ack", bus_fetch_read_ack, 1'b0);
        end
        cyc();
        check("fill_ack", bus_fetch_read_ack, 1'b1);
        check("fill_data", bus_fetch_data, 128'h00000044_00000033_00000022_00000011);
        fetch_bus_read_req = 1'b0;
        cyc();
        check("fill_ack_one_cycle", bus_fetch_read_ack, 1'b0);
        check("fill_ibus_idle", ibus_read_req, 1'b0);

        // Misaligned request
        ibus_cnt           = 0;
        fetch_bus_read_req = 1'b1;
        fetch_bus_addr     = 32'h8000_0002;
        cyc();
        check("mis_ack", bus_fetch_read_ack, 1'b1);
        check("mis_data", bus_fetch_data, '0);
        fetch_bus_read_req = 1'b0;
        cyc();
        check("mis_ack_drop", bus_fetch_read_ack, 1'b0);
        check("mis_no_ibus", 32'(ibus_cnt), 32'd0);

        // Redirect while beat 2 waits three cycles
        invalidate_cycle();
        redir_exp = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0008,
                      32'h8000_0008, 32'h8000_0008, 32'h8000_0100, 32'h8000_0104,
                      32'h8000_0108, 32'h8000_010C};
        fetch_bus_read_req = 1'b1;
        fetch_bus_addr     = 32'h8000_0000;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("redir_ibus_req", ibus_read_req, 1'b1);
            check("redir_ibus_addr", ibus_addr, redir_exp[i]);
            check("redir_no_ack", bus_fetch_read_ack, 1'b0);
            if (i == 1) mem_wait = 3;
            if (i == 2) fetch_bus_addr = 32'h8000_0100;
            if (i == 5) mem_wait = 0;
        end
        cyc();
        check("redir_ack", bus_fetch_read_ack, 1'b1);
        check("redir_data", bus_fetch_data, exp_block(32'h8000_0100));
        fetch_bus_read_req = 1'b0;
        cyc();

        // Back-to-back requests
        invalidate_cycle();
        fetch_bus_read_req = 1'b1;
        fetch_bus_addr     = 32'h8000_0000;
        for (int i = 0; i < FW; i++) cyc();
        cyc();
        check("b2b_ack1", bus_fetch_read_ack, 1'b1);
        fetch_bus_addr = 32'h8000_0010;
        cyc();
        check("b2b_ibus_req", ibus_read_req, 1'b1);
        check("b2b_ibus_addr", ibus_addr, 32'h8000_0010);
        check("b2b_ack_gap", bus_fetch_read_ack, 1'b0);
        for (int i = 1; i < FW; i++) begin
            cyc();
            check("b2b_ack_gap", bus_fetch_read_ack, 1'b0);
        end
        cyc();
        check("b2b_ack2", bus_fetch_read_ack, 1'b1);
        check("b2b_data2", bus_fetch_data, exp_block(32'h8000_0010));
        fetch_bus_read_req = 1'b0;
        cyc();

        // Reset in the middle of a fill
        invalidate_cycle();
        fetch_bus_read_req = 1'b1;
        fetch_bus_addr     = 32'h8000_0000;
        cyc();
        check("mrst_beat0", ibus_addr, 32'h8000_0000);
        rst      = 1'b1;
        mem_busy = 1'b0;
        cyc();
        check("mrst_ack", bus_fetch_read_ack, 1'b0);
        check("mrst_data", bus_fetch_data, '0);
        check("mrst_ibus_req", ibus_read_req, 1'b0);
        check("mrst_ibus_addr", ibus_addr, '0);
        rst            = 1'b0;
        fetch_bus_addr = 32'h8000_0020;
        for (int i = 0; i < FW; i++) begin
            cyc();
            check("mrst_refill_addr", ibus_addr, 32'h8000_0020 + AW'(4 * i));
            check("mrst_refill_no_ack", bus_fetch_read_ack, 1'b0);
        end
        cyc();
        check("mrst_refill_ack", bus_fetch_read_ack, 1'b1);
        check("mrst_refill_data", bus_fetch_data, exp_block(32'h8000_0020));
        fetch_bus_read_req = 1'b0;
        cyc();

`ifdef FETCH_BUS_LINE_BUFFER_EN
        // Line buffer hit, then miss after invalidate
        invalidate_cycle();
        fetch_bus_read_req = 1'b1;
        fetch_bus_addr     = 32'h8000_0000;
        for (int i = 0; i <= FW; i++) cyc();
        check("lb_fill_ack", bus_fetch_read_ack, 1'b1);
        fetch_bus_read_req = 1'b0;
        cyc();
        ibus_cnt           = 0;
        fetch_bus_read_req = 1'b1;
        cyc();
        check("lb_hit_ack", bus_fetch_read_ack, 1'b1);
        check("lb_hit_data", bus_fetch_data, 128'h00000044_00000033_00000022_00000011);
        check("lb_hit_no_ibus", 32'(ibus_cnt), 32'd0);
        fetch_bus_read_req = 1'b0;
        cyc();
        invalidate_cycle();
        fetch_bus_read_req = 1'b1;
        for (int i = 0; i < FW; i++) begin
            cyc();
            check("lb_miss_ibus_addr", ibus_addr, 32'h8000_0000 + AW'(4 * i));
            check("lb_miss_no_ack", bus_fetch_read_ack, 1'b0);
        end
        cyc();
        check("lb_miss_ack", bus_fetch_read_ack, 1'b1);
        check("lb_miss_data", bus_fetch_data, 128'h00000044_00000033_00000022_00000011);
        fetch_bus_read_req = 1'b0;
        cyc();
`endif

        // Randomized requests, redirects, drops and memory wait states. An
        // ack must carry the block of the address requested one cycle before.
        stall = 0;
        acks  = 0;
        for (int n = 0; n < 1500; n++) begin
            mem_wait = $urandom_range(0, 2);
            cyc();
            if (bus_fetch_read_ack) begin
                acks++;
                check("rnd_ack_had_req", fetch_bus_read_req, 1'b1);
                check("rnd_data", bus_fetch_data, exp_block(fetch_bus_addr));
            end
            fetch_bus_invalidate = ($urandom_range(0, 19) == 0);
            if (bus_fetch_read_ack || !fetch_bus_read_req) begin
                stall = 0;
                if ($urandom_range(0, 4) == 0) begin
                    fetch_bus_read_req = 1'b0;
                end else begin
                    fetch_bus_read_req = 1'b1;
                    fetch_bus_addr     = pick_addr();
                end
            end else begin
                stall++;
                if (stall > 40) begin
                    check("rnd_ack_within_bound", bus_fetch_read_ack, 1'b1);
                    stall          = 0;
                    fetch_bus_addr = pick_addr();
                end else if ($urandom_range(0, 15) == 0) begin
                    stall          = 0;
                    fetch_bus_addr = pick_addr();
                end else if ($urandom_range(0, 31) == 0) begin
                    fetch_bus_read_req = 1'b0;
                end
            end
        end
        check("rnd_acks_seen", (acks > 50), 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
